// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the systolic MAC array sequencer.
// Schedule states, mode encodings and saturation bounds.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic MODE_PIPE  = 1'b0;
  localparam logic MODE_LAYER = 1'b1;

  function automatic longint sat_max(input int aw);
    return (longint'(1) <<< (aw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int aw);
    return -(longint'(1) <<< (aw - 1));
  endfunction

endpackage

// File: rtl/mac_array_sequencer_lane.sv
// One weight-stationary MAC lane: signed multiply, widened add,
// clamp to the accumulator range and a sticky overflow flag.
module mac_lane
  import mac_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_w,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  localparam logic signed [ACC_W:0] SMAX =
    (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SMIN =
    (ACC_W+1)'(sat_min(ACC_W));
  localparam int EXT = ACC_W + 1 - 2*W;

  logic [ACC_W-1:0]        r_acc;
  logic                    r_ovf;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W:0]   w_prod_x;
  logic signed [ACC_W:0]   w_acc_x;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_hi;
  logic                    w_lo;
  logic [ACC_W-1:0]        w_next;

  assign w_prod   = $signed(i_a) * $signed(i_w);
  assign w_prod_x = {{EXT{w_prod[2*W-1]}}, w_prod};
  assign w_acc_x  = {r_acc[ACC_W-1], r_acc};
  assign w_sum    = w_acc_x + w_prod_x;
  assign w_hi     = w_sum > SMAX;
  assign w_lo     = w_sum < SMIN;

  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    if (w_hi) w_next = SMAX[ACC_W-1:0];
    if (w_lo) w_next = SMIN[ACC_W-1:0];
  end

  // A clear overrides an accumulate in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_next;
      if (w_hi || w_lo) r_ovf <= 1'b1;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_array_sequencer.sv
// Systolic MAC array top: unified pipeline/layering schedule FSM,
// activation delay chain, per-lane enable decode and pulse outputs.
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int KW     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic [KW-1:0]           i_k_len,
  input  logic [N_MACS*W-1:0]     i_w_in,
  input  logic [W-1:0]            i_a_in,
  input  logic                    i_clear_all,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N_MACS*ACC_W-1:0] o_acc_out,
  output logic [N_MACS-1:0]       o_valid_out,
  output logic [N_MACS-1:0]       o_ovf
);

  localparam int CW = KW + $clog2(N_MACS) + 1;
  localparam int DL = (N_MACS > 1) ? N_MACS - 1 : 1;

  state_t              r_state;
  state_t              w_next;
  logic                r_mode;
  logic [KW-1:0]       r_klen;
  logic [N_MACS*W-1:0] r_w;
  logic [CW-1:0]       r_cyc;
  logic [W-1:0]        r_dly [DL];
  logic [N_MACS-1:0]   r_valid;

  logic                w_accept;
  logic [CW-1:0]       w_klen_x;
  logic [CW-1:0]       w_run_len;
  logic                w_last;
  logic                w_clr;
  logic [N_MACS-1:0]   w_en;
  logic [N_MACS-1:0]   w_vn;

  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_klen_x  = CW'(r_klen);
  assign w_run_len = (r_mode == MODE_LAYER) ? w_klen_x
                   : w_klen_x + CW'(N_MACS - 1);
  assign w_last    = r_cyc == (w_run_len - CW'(1));
  assign w_clr     = i_clear_all || w_accept;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (i_k_len == '0) ? DONE : RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_klen  <= '0;
      r_w     <= '0;
      r_cyc   <= '0;
      r_valid <= '0;
      for (int k = 0; k < DL; k++) r_dly[k] <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_vn;
      r_dly[0] <= i_a_in;
      for (int k = 1; k < DL; k++) r_dly[k] <= r_dly[k-1];
      if (w_accept) begin
        r_mode <= i_mode;
        r_klen <= i_k_len;
        r_w    <= i_w_in;
        r_cyc  <= '0;
      end else if (r_state == RUN) begin
        r_cyc <= r_cyc + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    localparam logic [CW-1:0] LI = CW'(i);
    logic [W-1:0]  w_a;
    logic [CW-1:0] w_beg;
    logic [CW-1:0] w_end;

    // Pipeline lanes see the stream staggered by their index.
    if (i == 0) begin : g_a0
      assign w_a = i_a_in;
    end else begin : g_an
      assign w_a = (r_mode == MODE_LAYER) ? i_a_in : r_dly[i-1];
    end

    assign w_beg = (r_mode == MODE_LAYER) ? '0 : LI;
    assign w_end = w_beg + w_klen_x;
    assign w_en[i] = (r_state == RUN) &&
                     (r_cyc >= w_beg) && (r_cyc < w_end);
    assign w_vn[i] = w_en[i] && ((r_cyc + CW'(1)) == w_end);

    mac_lane #(
      .W     (W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_en[i]),
      .i_a   (w_a),
      .i_w   (r_w[i*W +: W]),
      .o_acc (o_acc_out[i*ACC_W +: ACC_W]),
      .o_ovf (o_ovf[i])
    );
  end

  assign o_busy      = r_state != IDLE;
  assign o_done      = r_state == DONE;
  assign o_valid_out = r_valid;

endmodule
